// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive DMA path.
// Holds default widths and the 2-bit state codes of the drain sequencer.
package udp_pkg;

  localparam int unsigned UDP_DATA_W   = 32;
  localparam int unsigned UDP_HANG_LEN = 256;
  localparam int unsigned SYN_ADDR_W   = 17;

  // Drain sequencer states, kept as plain constants for legacy tools.
  typedef logic [1:0] udp_state_t;
  localparam udp_state_t StIdle  = 2'd0;
  localparam udp_state_t StRead  = 2'd1;
  localparam udp_state_t StDrain = 2'd2;
  localparam udp_state_t StAck   = 2'd3;

endpackage

// File: rtl/udp_rx_dma_ctrl_if.sv
// FIFO read port plus synapse-SRAM write port of the UDP receive DMA.
//   master (DMA side): drives fifo_rd, mem_we, mem_addr, mem_wdata; samples fifo_dout
//   slave  (FIFO/SRAM side): the mirror image
interface udp_rx_dma_ctrl_if #(
  parameter int unsigned DATA_W = udp_pkg::UDP_DATA_W,
  parameter int unsigned ADDR_W = udp_pkg::SYN_ADDR_W
);

  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output fifo_rd,
    input  fifo_dout,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    input  fifo_rd,
    output fifo_dout,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/udp_pend_cnt.sv
// Saturating pending-packet counter with sticky overflow flag.
//   clk_i/rst_i : clock, synchronous active-high reset
//   inc_i       : a packet was announced
//   dec_i       : a packet finished draining
//   clr_i       : clear the overflow flag
//   cnt_o       : queued packet count
//   ovf_o       : an increment arrived while the count was at MAX
module udp_pend_cnt #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovf_hit;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ovf_hit = 1'b0;
    // Simultaneous inc and dec cancel, so a full queue cannot overflow then.
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_W'(MAX)) begin
        ovf_hit = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    // A fresh overflow beats a same-cycle clear.
    if (ovf_hit) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/udp_rx_dma_ctrl.sv
// UDP receive DMA sequencer: for every queued packet, reads HANG_LEN words from the UDP RX
// FIFO and writes them to consecutive synapse-SRAM addresses, then acknowledges.
//   hclk_i, hrst_i : clock, synchronous active-high reset
//   en_i           : allows a new packet drain to start
//   pkt_rdy_i      : pulse, one packet buffered in the FIFO
//   base_addr_i    : SRAM start address, taken on ptr_load_i
//   ptr_load_i     : pulse, reload the write pointer
//   err_clr_i      : pulse, clear ovf_err_o
//   bus            : FIFO read port and SRAM write port
//   udp_tx_req_o   : one-cycle acknowledge to udp_top
//   done_o         : one-cycle packet-complete pulse
//   busy_o         : sequencer not idle
//   pend_cnt_o     : queued packet count
//   ovf_err_o      : sticky, packet announced while queue full
module udp_rx_dma_ctrl
  import udp_pkg::*;
#(
  parameter int unsigned DATA_W     = UDP_DATA_W,
  parameter int unsigned HANG_LEN   = UDP_HANG_LEN,
  parameter int unsigned HANG_LEN_B = 8,
  parameter int unsigned ADDR_W     = SYN_ADDR_W,
  parameter int unsigned PEND_MAX   = 3
) (
  input  logic              hclk_i,
  input  logic              hrst_i,
  input  logic              en_i,
  input  logic              pkt_rdy_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              ptr_load_i,
  input  logic              err_clr_i,
  udp_rx_dma_ctrl_if.master bus,
  output logic              udp_tx_req_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [1:0]        pend_cnt_o,
  output logic              ovf_err_o
);

  localparam logic [HANG_LEN_B-1:0] LastWord = HANG_LEN_B'(HANG_LEN - 1);

  udp_state_t            state_q, state_d;
  logic [HANG_LEN_B-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic                  we_q;
  logic [1:0]            pend_cnt;
  logic                  rd;
  logic                  ack;

  assign rd  = (state_q == StRead);
  assign ack = (state_q == StAck);

  udp_pend_cnt #(
    .CNT_W (2),
    .MAX   (PEND_MAX)
  ) u_pend_cnt (
    .clk_i (hclk_i),
    .rst_i (hrst_i),
    .inc_i (pkt_rdy_i),
    .dec_i (ack),
    .clr_i (err_clr_i),
    .cnt_o (pend_cnt),
    .ovf_o (ovf_err_o)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        // en only gates leaving IDLE; a running packet always completes.
        if (en_i && (pend_cnt != 2'd0)) begin
          state_d = StRead;
          cnt_d   = '0;
        end
      end
      StRead: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastWord) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A reload coinciding with a write lets that write use the old address.
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_load_i) begin
      ptr_d = base_addr_i;
    end else if (we_q) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= rd;
    end
  end

  // FIFO data arrives one cycle after the read, aligned with the delayed write enable.
  assign bus.fifo_rd   = rd;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_wdata = bus.fifo_dout;

  assign udp_tx_req_o = ack;
  assign done_o       = ack;
  assign busy_o       = (state_q != StIdle);
  assign pend_cnt_o   = pend_cnt;

endmodule

// File: tb/tb_udp_rx_dma_ctrl.sv
module tb_udp_rx_dma_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 17;
  localparam int          HL   = 256;
  localparam int          PMAX = 3;
  localparam int          SVC  = HL + 2;  // busy cycles per packet: reads, drain, ack

  logic          hclk = 1'b0;
  logic          hrst, en, pkt_rdy, ptr_load, err_clr;
  logic [AW-1:0] base_addr;
  logic          udp_tx_req, done, busy, ovf_err;
  logic [1:0]    pend_cnt;

  always #5 hclk = ~hclk;

  udp_rx_dma_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  udp_rx_dma_ctrl #(
    .DATA_W     (DW),
    .HANG_LEN   (HL),
    .HANG_LEN_B (8),
    .ADDR_W     (AW),
    .PEND_MAX   (PMAX)
  ) dut (
    .hclk_i       (hclk),
    .hrst_i       (hrst),
    .en_i         (en),
    .pkt_rdy_i    (pkt_rdy),
    .base_addr_i  (base_addr),
    .ptr_load_i   (ptr_load),
    .err_clr_i    (err_clr),
    .bus          (bus),
    .udp_tx_req_o (udp_tx_req),
    .done_o       (done),
    .busy_o       (busy),
    .pend_cnt_o   (pend_cnt),
    .ovf_err_o    (ovf_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue count, a countdown of remaining service cycles, a pointer.
  int          m_left, m_pend, m_ptr;
  int unsigned m_rdcnt, m_wexp;
  bit          m_ovf, m_we, m_valid;

  // Observation stats
  int          cyc;
  int          n_we, n_done, n_busy, n_addr0;
  int          first_addr, last_addr;
  int unsigned first_data, last_data;
  int          done_cycs[$];
  logic [DW-1:0] rd_total;

  typedef struct {
    logic       pkt;
    logic       clr;
    logic [1:0] pend;
    logic       ovf;
  } qvec_t;
  qvec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_we = 0; n_done = 0; n_busy = 0; n_addr0 = 0;
    first_addr = -1; last_addr = -1; first_data = 0; last_data = 0;
    done_cycs.delete();
  endtask

  // One clock: check outputs at negedge, advance the model with this cycle's inputs,
  // answer a FIFO read after the edge, then drop one-shot inputs.
  task automatic cycle();
    logic rd_s;
    bit   exp_rd, exp_ack, ovf_new;
    int   pend_old;
    @(negedge hclk);
    rd_s    = bus.fifo_rd;
    exp_rd  = (m_left >= 3);
    exp_ack = (m_left == 1);
    if (m_valid) begin
      chk("busy", busy, m_left != 0);
      chk("fifo_rd", rd_s, exp_rd);
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_ptr);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wexp);
      chk("done", done, exp_ack);
      chk("udp_tx_req", udp_tx_req, exp_ack);
      chk("pend_cnt", pend_cnt, m_pend);
      chk("ovf_err", ovf_err, m_ovf);
    end
    if (bus.mem_we === 1'b1) begin
      if (n_we == 0) begin
        first_addr = int'(bus.mem_addr);
        first_data = bus.mem_wdata;
      end
      last_addr = int'(bus.mem_addr);
      last_data = bus.mem_wdata;
      if (bus.mem_addr == '0) n_addr0++;
      n_we++;
    end
    if (done === 1'b1) begin
      n_done++;
      done_cycs.push_back(cyc);
    end
    if (busy === 1'b1) n_busy++;

    if (exp_rd) begin
      m_wexp = m_rdcnt;
      m_rdcnt++;
    end
    if (hrst) begin
      m_left = 0; m_pend = 0; m_ovf = 0; m_ptr = 0; m_we = 0; m_valid = 1;
    end else begin
      pend_old = m_pend;
      ovf_new  = 0;
      if (pkt_rdy && !exp_ack) begin
        if (m_pend == PMAX) ovf_new = 1;
        else m_pend++;
      end else if (exp_ack && !pkt_rdy) begin
        m_pend--;
      end
      m_ovf = ovf_new ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      if (ptr_load) m_ptr = int'(base_addr);
      else if (m_we) m_ptr = (m_ptr + 1) % (1 << AW);
      m_we = exp_rd;
      if (m_left != 0) m_left--;
      else if (en && pend_old != 0) m_left = SVC;
    end

    @(posedge hclk);
    #1;
    if (rd_s === 1'b1) begin
      bus.fifo_dout = rd_total;
      rd_total++;
    end
    pkt_rdy  = 1'b0;
    ptr_load = 1'b0;
    err_clr  = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_done(input int want, input int budget, input string name);
    int k = 0;
    while (n_done < want && k < budget) begin
      cycle();
      k++;
    end
    chk(name, n_done, want);
  endtask

  // Step until the model reaches a given point of the service countdown.
  task automatic run_until_left(input int target, input int budget, input string name);
    int k = 0;
    while (m_left != target && k < budget) begin
      cycle();
      k++;
    end
    chk(name, busy, 1);
  endtask

  initial begin
    int t0;
    hrst = 1'b1; en = 1'b0; pkt_rdy = 1'b0; ptr_load = 1'b0; err_clr = 1'b0;
    base_addr = '0; bus.fifo_dout = '0; rd_total = '0;
    m_left = 0; m_pend = 0; m_ptr = 0; m_rdcnt = 0; m_wexp = 0;
    m_ovf = 0; m_we = 0; m_valid = 0; cyc = 0;
    clr_stats();

    // Reset state
    run(2);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_rd", bus.fifo_rd, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", ovf_err, 0);
    hrst = 1'b0;

    // 1: single packet from 0x100
    base_addr = 17'h00100; ptr_load = 1'b1;
    cycle();
    en = 1'b1;
    clr_stats();
    t0 = cyc;
    pkt_rdy = 1'b1;
    cycle();
    run_until_done(1, 400, "t1_done_seen");
    run(3);
    chk("t1_we_count", n_we, 256);
    chk("t1_first_addr", first_addr, 32'h100);
    chk("t1_last_addr", last_addr, 32'h1FF);
    chk("t1_first_data", first_data, 0);
    chk("t1_last_data", last_data, 255);
    chk("t1_done_latency", done_cycs.size() > 0 ? done_cycs[0] - t0 : -1, 259);
    chk("t1_done_count", n_done, 1);
    chk("t1_pend", pend_cnt, 0);

    // 2: queue saturation and overflow flag, table-driven, then drain three
    en = 1'b0;
    tbl[0] = '{1'b1, 1'b0, 2'd1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'd2, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 2'd3, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 2'd3, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 2'd3, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 2'd3, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2'd3, 1'b0};
    for (int i = 0; i < 8; i++) begin
      pkt_rdy = tbl[i].pkt;
      err_clr = tbl[i].clr;
      cycle();
      chk("q_pend", pend_cnt, tbl[i].pend);
      chk("q_ovf", ovf_err, tbl[i].ovf);
    end
    clr_stats();
    en = 1'b1;
    run_until_done(3, 1000, "t2_done_seen");
    run(3);
    chk("t2_we_count", n_we, 768);
    chk("t2_done_count", n_done, 3);
    chk("t2_gap01", done_cycs.size() > 1 ? done_cycs[1] - done_cycs[0] : -1, 259);
    chk("t2_gap12", done_cycs.size() > 2 ? done_cycs[2] - done_cycs[1] : -1, 259);
    chk("t2_pend", pend_cnt, 0);

    // 3: address wrap
    base_addr = 17'h1FFF0; ptr_load = 1'b1;
    cycle();
    clr_stats();
    pkt_rdy = 1'b1;
    cycle();
    run_until_done(1, 400, "t3_done_seen");
    run(3);
    chk("t3_we_count", n_we, 256);
    chk("t3_first_addr", first_addr, 32'h1FFF0);
    chk("t3_last_addr", last_addr, 32'h000EF);
    chk("t3_addr0_hits", n_addr0, 1);

    // 4: pkt_rdy coincident with ACK at full queue
    en = 1'b0;
    repeat (3) begin
      pkt_rdy = 1'b1;
      cycle();
    end
    chk("t4_pend_full", pend_cnt, 3);
    en = 1'b1;
    run_until_left(1, 400, "t4_reach_ack");
    pkt_rdy = 1'b1;
    cycle();
    chk("t4_pend_hold", pend_cnt, 3);
    chk("t4_no_ovf", ovf_err, 0);
    run(2);
    chk("t4_restart", bus.fifo_rd, 1);

    // 5: reset at word 100
    run_until_left(SVC - 100, 400, "t5_reach_w100");
    hrst = 1'b1;
    cycle();
    hrst = 1'b0;
    clr_stats();
    chk("t5_busy", busy, 0);
    chk("t5_fifo_rd", bus.fifo_rd, 0);
    chk("t5_mem_we", bus.mem_we, 0);
    chk("t5_pend", pend_cnt, 0);
    chk("t5_mem_addr", bus.mem_addr, 0);
    chk("t5_done", done, 0);
    run(5);
    chk("t5_no_done", n_done, 0);

    // 6: en dropped mid-packet
    pkt_rdy = 1'b1;
    cycle();
    run_until_left(SVC - 10, 400, "t6_reach_w10");
    en = 1'b0;
    run_until_done(1, 400, "t6_done_seen");
    run(3);
    chk("t6_we_count", n_we, 256);
    clr_stats();
    pkt_rdy = 1'b1;
    cycle();
    run(20);
    chk("t6_hold_busy", n_busy, 0);
    chk("t6_hold_pend", pend_cnt, 1);
    en = 1'b1;
    run_until_done(1, 400, "t6_resume_done");

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      pkt_rdy = ($urandom_range(0, 149) == 0);
      en      = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 99) == 0);
      hrst    = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 299) == 0) begin
        ptr_load  = 1'b1;
        base_addr = AW'($urandom);
      end
      cycle();
    end
    hrst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
